// File: rtl/eight_lane_dot_product_pkg.sv
// Shared constants, lane types and the lane-slice helper for the eight-lane
// dot-product engine.
package eight_lane_dot_product_pkg;

   localparam int unsigned ELEMENT_WIDTH = 32;
   localparam int unsigned NO_OF_UNITS   = 8;
   localparam int unsigned BUS_WIDTH     = ELEMENT_WIDTH * NO_OF_UNITS;

   typedef logic [ELEMENT_WIDTH-1:0]                  elem_t;
   typedef logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0] lanes_t;

   // Lane idx of a flat bus: bits [32*idx+31 : 32*idx].
   function automatic elem_t lane_slice(input logic [BUS_WIDTH-1:0] bus,
                                        input int unsigned           idx);
      return bus[idx*ELEMENT_WIDTH +: ELEMENT_WIDTH];
   endfunction

endpackage : eight_lane_dot_product_pkg

// File: rtl/eight_lane_dot_product_adder_tree8.sv
// adder_tree8: registered 8-input wrapping sum.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-high reset
//   operand_i  eight 32-bit operands
//   sum_o      registered 32-bit sum, wraps modulo 2^32
module adder_tree8
   import eight_lane_dot_product_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  lanes_t operand_i,
   output elem_t  sum_o
);

   elem_t l1_0, l1_1, l1_2, l1_3;
   elem_t l2_0, l2_1;
   elem_t sum_d, sum_q;

   // Balanced three-level tree; every adder truncates to 32 bits.
   always_comb begin
      l1_0  = operand_i[0] + operand_i[1];
      l1_1  = operand_i[2] + operand_i[3];
      l1_2  = operand_i[4] + operand_i[5];
      l1_3  = operand_i[6] + operand_i[7];
      l2_0  = l1_0 + l1_1;
      l2_1  = l1_2 + l1_3;
      sum_d = l2_0 + l2_1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sum_q <= '0;
      else       sum_q <= sum_d;
   end

   assign sum_o = sum_q;

endmodule : adder_tree8

// File: rtl/eight_lane_dot_product.sv
// Eight-lane dot-product engine. Samples one 8-pair chunk on each of the first
// CHUNKS edges after reset, multiplies lane-wise, sums through a registered
// adder tree and accumulates. result/finish update together at edge CHUNKS+2
// and then hold until the next reset.
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-high reset (aborts any operation)
//   first_row_input   row operand chunk, lane i = bits [32i+31:32i]
//   second_row_input  vector operand chunk, same lane layout
//   result            complete dot product (0 until finish)
//   finish            high once result holds the complete dot product
module eight_lane_dot_product
   import eight_lane_dot_product_pkg::lane_slice;
   import eight_lane_dot_product_pkg::lanes_t;
#(
   parameter int unsigned NOE           = 16,
   // Fixed for this block; must match the package constants.
   parameter int unsigned NO_OF_UNITS   = 8,
   parameter int unsigned ELEMENT_WIDTH = 32
)(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] first_row_input,
   input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] second_row_input,
   output logic [ELEMENT_WIDTH-1:0]             result,
   output logic                                 finish
);

   localparam int unsigned CHUNKS = (NOE + NO_OF_UNITS - 1) / NO_OF_UNITS;
   localparam int unsigned CNT_W  = $clog2(CHUNKS + 3);

   // cnt_q = number of edges seen since reset, saturating at CHUNKS+2.
   localparam logic [CNT_W-1:0] CNT_SAMPLE_END = CNT_W'(CHUNKS);
   localparam logic [CNT_W-1:0] CNT_ACC_FIRST  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_ACC_LAST   = CNT_W'(CHUNKS + 1);
   localparam logic [CNT_W-1:0] CNT_DONE       = CNT_W'(CHUNKS + 2);

   logic [CNT_W-1:0]         cnt_q, cnt_d;
   lanes_t                   prod_q, prod_d;
   logic [ELEMENT_WIDTH-1:0] tree_sum;
   logic [ELEMENT_WIDTH-1:0] acc_q, acc_d;
   logic [ELEMENT_WIDTH-1:0] result_q, result_d;
   logic                     finish_q, finish_d;

   logic sample_en_c;
   logic acc_en_c;
   logic acc_first_c;
   logic acc_last_c;

   // Edge classification: sample on edges 1..CHUNKS, accumulate on 3..CHUNKS+2.
   always_comb begin
      sample_en_c = (cnt_q < CNT_SAMPLE_END);
      acc_en_c    = (cnt_q >= CNT_ACC_FIRST) && (cnt_q <= CNT_ACC_LAST);
      acc_first_c = (cnt_q == CNT_ACC_FIRST);
      acc_last_c  = (cnt_q == CNT_ACC_LAST);
   end

   // Lane multipliers; the low 32 bits of a product are the same for signed
   // and unsigned operands, so the truncated product needs no sign handling.
   for (genvar g = 0; g < NO_OF_UNITS; g++) begin : g_lane
      assign prod_d[g] = sample_en_c
                       ? lane_slice(first_row_input, g) * lane_slice(second_row_input, g)
                       : prod_q[g];
   end

   adder_tree8 u_tree (
      .clk_i     (clk),
      .rst_i     (reset),
      .operand_i (prod_q),
      .sum_o     (tree_sum)
   );

   // Counter, accumulator and completion update.
   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      finish_d = finish_q;
      if (cnt_q != CNT_DONE) cnt_d = cnt_q + CNT_W'(1);
      if (acc_en_c) acc_d = acc_first_c ? tree_sum : (acc_q + tree_sum);
      if (acc_last_c) begin
         result_d = acc_d;
         finish_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         prod_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         finish_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         finish_q <= finish_d;
      end
   end

   assign result = result_q;
   assign finish = finish_q;

endmodule : eight_lane_dot_product

// File: tb/tb_eight_lane_dot_product.sv
// Bench for eight_lane_dot_product: three instances (NOE=16, 8, 20), expected
// results queued when an operation starts and popped when finish is due.
module tb_eight_lane_dot_product;

   typedef logic [255:0] chunk_t;

   logic        clk = 1'b0;
   logic        rst   [3];
   chunk_t      a_in  [3];
   chunk_t      b_in  [3];
   logic [31:0] res   [3];
   logic        fin   [3];

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   eight_lane_dot_product #(.NOE(16)) u_noe16 (
      .clk(clk), .reset(rst[0]), .first_row_input(a_in[0]),
      .second_row_input(b_in[0]), .result(res[0]), .finish(fin[0]));

   eight_lane_dot_product #(.NOE(8)) u_noe8 (
      .clk(clk), .reset(rst[1]), .first_row_input(a_in[1]),
      .second_row_input(b_in[1]), .result(res[1]), .finish(fin[1]));

   eight_lane_dot_product #(.NOE(20)) u_noe20 (
      .clk(clk), .reset(rst[2]), .first_row_input(a_in[2]),
      .second_row_input(b_in[2]), .result(res[2]), .finish(fin[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic chunk_t fill(input logic [31:0] v);
      chunk_t c;
      for (int i = 0; i < 8; i++) c[i*32 +: 32] = v;
      return c;
   endfunction

   // Reference: 64-bit signed products, summed and kept modulo 2^32.
   function automatic logic [31:0] model(input int n, input chunk_t ca [3], input chunk_t cb [3]);
      longint      p;
      logic [31:0] s = '0;
      for (int k = 0; k < n; k++)
         for (int i = 0; i < 8; i++) begin
            p = longint'($signed(ca[k][i*32 +: 32])) * longint'($signed(cb[k][i*32 +: 32]));
            s = s + p[31:0];
         end
      return s;
   endfunction

   // Reset instance idx, stream n chunks (then junk), check every edge up to finish.
   task automatic run_op(input int idx, input int n, input chunk_t ca [3],
                         input chunk_t cb [3], input logic [31:0] exp);
      rst[idx]  = 1'b1;
      a_in[idx] = '0;
      b_in[idx] = '0;
      @(negedge clk);
      check("reset_result", res[idx], 32'd0);
      check("reset_finish", 32'(fin[idx]), 32'd0);
      rst[idx]  = 1'b0;
      a_in[idx] = ca[0];
      b_in[idx] = cb[0];
      exp_q.push_back(exp);
      for (int e = 1; e <= n + 2; e++) begin
         @(negedge clk);
         if (e < n) begin
            a_in[idx] = ca[e];
            b_in[idx] = cb[e];
         end else begin
            a_in[idx] = fill(32'($urandom));
            b_in[idx] = fill(32'($urandom));
         end
         if (e < n + 2) begin
            check("busy_result", res[idx], 32'd0);
            check("busy_finish", 32'(fin[idx]), 32'd0);
         end else begin
            check("done_finish", 32'(fin[idx]), 32'd1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
               check("done_result", res[idx], exp_q.pop_front());
            end
         end
      end
   endtask

   initial begin
      chunk_t ca [3];
      chunk_t cb [3];
      logic [31:0] e;

      for (int i = 0; i < 3; i++) begin
         rst[i]  = 1'b1;
         a_in[i] = '0;
         b_in[i] = '0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("init_result", res[i], 32'd0);
         check("init_finish", 32'(fin[i]), 32'd0);
      end

      // NOE=16: (1..8).1 + 2*3*8 = 36 + 48 = 84
      for (int i = 0; i < 8; i++) ca[0][i*32 +: 32] = 32'(i + 1);
      cb[0] = fill(32'd1);
      ca[1] = fill(32'd2);
      cb[1] = fill(32'd3);
      ca[2] = '0;
      cb[2] = '0;
      run_op(0, 2, ca, cb, 32'd84);

      // Hold after finish while new operands arrive.
      for (int c = 0; c < 5; c++) begin
         a_in[0] = fill(32'd7);
         b_in[0] = fill(32'd7);
         @(negedge clk);
         check("hold_result", res[0], 32'd84);
         check("hold_finish", 32'(fin[0]), 32'd1);
      end
      // Asynchronous clear of a finished result.
      rst[0] = 1'b1;
      #1;
      check("async_clr_result", res[0], 32'd0);
      check("async_clr_finish", 32'(fin[0]), 32'd0);

      // NOE=8: -1 * 5 * 8 = -40
      ca[0] = fill(32'hFFFF_FFFF);
      cb[0] = fill(32'd5);
      run_op(1, 1, ca, cb, 32'hFFFF_FFD8);

      // NOE=8: 0x10000^2 wraps to 0, plus 3*4 = 12
      ca[0] = '0;
      cb[0] = '0;
      ca[0][31:0]  = 32'h0001_0000;
      cb[0][31:0]  = 32'h0001_0000;
      ca[0][63:32] = 32'd3;
      cb[0][63:32] = 32'd4;
      run_op(1, 1, ca, cb, 32'd12);

      // NOE=16: abort after edge 2, then a clean all-ones run gives 16.
      @(negedge clk);
      rst[0] = 1'b0;
      a_in[0] = fill(32'd1);
      b_in[0] = fill(32'd1);
      repeat (2) @(negedge clk);
      rst[0] = 1'b1;
      #1;
      check("abort_result", res[0], 32'd0);
      check("abort_finish", 32'(fin[0]), 32'd0);
      ca[0] = fill(32'd1);
      cb[0] = fill(32'd1);
      ca[1] = fill(32'd1);
      cb[1] = fill(32'd1);
      run_op(0, 2, ca, cb, 32'd16);

      // NOE=20: two full chunks of ones plus four padded lanes -> 20.
      ca[2] = '0;
      cb[2] = '0;
      for (int i = 0; i < 4; i++) begin
         ca[2][i*32 +: 32] = 32'd1;
         cb[2][i*32 +: 32] = 32'd1;
      end
      run_op(2, 3, ca, cb, 32'd20);

      // NOE=20 random signed operands, padding lanes zeroed.
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) begin
               ca[k][i*32 +: 32] = (k == 2 && i >= 4) ? 32'd0 : 32'($urandom);
               cb[k][i*32 +: 32] = (k == 2 && i >= 4) ? 32'd0 : 32'($urandom);
            end
         e = model(3, ca, cb);
         run_op(2, 3, ca, cb, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_eight_lane_dot_product
